bram_sp_arbiter: RTL and testbench

BRAM_SP_ARBITER -- requirements
Module: bram_sp_arbiter

---
 rtl/bram_sp_arbiter.sv | 176 +++++++++++++++++
 tb/tb_bram_sp_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sp_arbiter.sv
// rtl/bram_sp_arbiter.sv - two-port round-robin/lock arbiter onto a single-port BRAM with 2-cycle read return
module bram_sp_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clka,
    input  logic              rsta,

    input  logic              req_p0,
    input  logic              lock_p0,
    input  logic              we_p0,
    input  logic [BE_W-1:0]   be_p0,
    input  logic [ADDR_W-1:0] addr_p0,
    input  logic [DATA_W-1:0] wdata_p0,
    output logic              gnt_p0,
    output logic              rvalid_p0,
    output logic [DATA_W-1:0] rdata_p0,

    input  logic              req_p1,
    input  logic              lock_p1,
    input  logic              we_p1,
    input  logic [BE_W-1:0]   be_p1,
    input  logic [ADDR_W-1:0] addr_p1,
    input  logic [DATA_W-1:0] wdata_p1,
    output logic              gnt_p1,
    output logic              rvalid_p1,
    output logic [DATA_W-1:0] rdata_p1,

    output logic              ena,
    output logic [BE_W-1:0]   wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta
);

    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    logic   prio;          // 0: port 0 wins a tie, 1: port 1 wins a tie

    logic              arb_open;
    logic              g0;
    logic              g1;
    logic              accept;
    logic              sel_we;
    logic [BE_W-1:0]   sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Read tag pipeline: stage 1 rides with ena, stage 2 lines up with douta.
    logic              tag1_v;
    logic              tag1_p;
    logic              tag2_v;
    logic              tag2_p;
    logic [DATA_W-1:0] hold_p0;
    logic [DATA_W-1:0] hold_p1;

    // A lock whose owner drops lock_pn is arbitrated as OPEN in that same cycle.
    always_comb begin
        arb_open = 1'b0;
        g0       = 1'b0;
        g1       = 1'b0;
        case (state)
            LOCK0:   arb_open = !lock_p0;
            LOCK1:   arb_open = !lock_p1;
            default: arb_open = 1'b1;
        endcase
        if (!rsta) begin
            if (arb_open) begin
                if (req_p0 && req_p1) begin
                    g0 = !prio;
                    g1 = prio;
                end else begin
                    g0 = req_p0;
                    g1 = req_p1;
                end
            end else if (state == LOCK0) begin
                g0 = req_p0;
            end else begin
                g1 = req_p1;
            end
        end
    end

    assign gnt_p0 = g0;
    assign gnt_p1 = g1;
    assign accept = g0 || g1;

    always_comb begin
        sel_we    = we_p0;
        sel_be    = be_p0;
        sel_addr  = addr_p0;
        sel_wdata = wdata_p0;
        if (g1) begin
            sel_we    = we_p1;
            sel_be    = be_p1;
            sel_addr  = addr_p1;
            sel_wdata = wdata_p1;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state <= OPEN;
            prio  <= 1'b0;
        end else if (arb_open) begin
            if (g0) begin
                prio  <= 1'b1;
                state <= lock_p0 ? LOCK0 : OPEN;
            end else if (g1) begin
                prio  <= 1'b0;
                state <= lock_p1 ? LOCK1 : OPEN;
            end else begin
                state <= OPEN;
            end
        end
    end

    // Zero-byte-enable writes are accepted but never reach the memory.
    always_ff @(posedge clka) begin
        if (rsta) begin
            ena    <= 1'b0;
            wea    <= '0;
            addra  <= '0;
            dina   <= '0;
            tag1_v <= 1'b0;
            tag1_p <= 1'b0;
            tag2_v <= 1'b0;
            tag2_p <= 1'b0;
        end else begin
            ena    <= 1'b0;
            wea    <= '0;
            tag1_v <= 1'b0;
            if (accept) begin
                if (!sel_we) begin
                    ena    <= 1'b1;
                    addra  <= sel_addr;
                    tag1_v <= 1'b1;
                    tag1_p <= g1;
                end else if (sel_be != '0) begin
                    ena   <= 1'b1;
                    wea   <= sel_be;
                    addra <= sel_addr;
                    dina  <= sel_wdata;
                end
            end
            tag2_v <= tag1_v;
            tag2_p <= tag1_p;
        end
    end

    assign rvalid_p0 = tag2_v && !tag2_p && !rsta;
    assign rvalid_p1 = tag2_v &&  tag2_p && !rsta;
    assign rdata_p0  = rvalid_p0 ? douta : hold_p0;
    assign rdata_p1  = rvalid_p1 ? douta : hold_p1;

    always_ff @(posedge clka) begin
        if (rsta) begin
            hold_p0 <= '0;
            hold_p1 <= '0;
        end else begin
            if (rvalid_p0) begin
                hold_p0 <= douta;
            end
            if (rvalid_p1) begin
                hold_p1 <= douta;
            end
        end
    end

endmodule

// File: tb/tb_bram_sp_arbiter.sv
// tb/tb_bram_sp_arbiter.sv - scoreboard bench for bram_sp_arbiter with a 1-cycle BRAM model
module tb_bram_sp_arbiter;

    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic        req_p0 = 0, lock_p0 = 0, we_p0 = 0;
    logic        req_p1 = 0, lock_p1 = 0, we_p1 = 0;
    logic [3:0]  be_p0 = 0, be_p1 = 0;
    logic [31:0] addr_p0 = 0, addr_p1 = 0, wdata_p0 = 0, wdata_p1 = 0;
    logic        gnt_p0, gnt_p1, rvalid_p0, rvalid_p1;
    logic [31:0] rdata_p0, rdata_p1;
    logic        ena;
    logic [3:0]  wea;
    logic [31:0] addra, dina;
    logic [31:0] douta = 0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clka = ~clka;

    bram_sp_arbiter #(.ADDR_W(32), .DATA_W(32), .BE_W(4)) dut (
        .clka(clka), .rsta(rsta),
        .req_p0(req_p0), .lock_p0(lock_p0), .we_p0(we_p0), .be_p0(be_p0),
        .addr_p0(addr_p0), .wdata_p0(wdata_p0), .gnt_p0(gnt_p0),
        .rvalid_p0(rvalid_p0), .rdata_p0(rdata_p0),
        .req_p1(req_p1), .lock_p1(lock_p1), .we_p1(we_p1), .be_p1(be_p1),
        .addr_p1(addr_p1), .wdata_p1(wdata_p1), .gnt_p1(gnt_p1),
        .rvalid_p1(rvalid_p1), .rdata_p1(rdata_p1),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
    );

    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'hA5A50000 + i;
            shadow[i] = 32'hA5A50000 + i;
        end
    end

    always @(posedge clka) begin
        if (ena) begin
            if (wea == 4'b0000) begin
                douta <= mem[addra[9:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (wea[b]) mem[addra[9:2]][8*b +: 8] <= dina[8*b +: 8];
                end
            end
        end
    end

    typedef struct packed {
        logic        we;
        logic        lock;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    function automatic txn_t rd(input logic [31:0] a, input logic lk);
        txn_t t;
        t.we = 1'b0; t.lock = lk; t.be = 4'b0000; t.addr = a; t.wdata = 32'h0;
        return t;
    endfunction

    function automatic txn_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        txn_t t;
        t.we = 1'b1; t.lock = 1'b0; t.be = be; t.addr = a; t.wdata = d;
        return t;
    endfunction

    txn_t q0[$];
    txn_t q1[$];
    int   gseq[$];
    exp_t sb0[$];
    exp_t sb1[$];

    // Reference model of the memory-side outputs and the read return stream.
    logic [31:0] cyc = 0;
    logic        exp_ena = 0;
    logic [3:0]  exp_wea = 0;
    logic [31:0] exp_addra = 0, exp_dina = 0;
    logic [31:0] last0 = 0, last1 = 0;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    exp_t        e;

    always @(negedge clka) begin
        cyc = cyc + 1;
        n_chk++;
        if (ena === exp_ena && wea === exp_wea && addra === exp_addra && dina === exp_dina) n_pass++;
        else $display("FAIL mem_port cyc=%0d got ena=%b wea=%b addra=%h dina=%h exp ena=%b wea=%b addra=%h dina=%h",
                      cyc, ena, wea, addra, dina, exp_ena, exp_wea, exp_addra, exp_dina);
        n_chk++;
        if (!(gnt_p0 && gnt_p1) && !(rsta && (gnt_p0 || gnt_p1))) n_pass++;
        else $display("FAIL gnt_rules cyc=%0d got gnt_p0=%b gnt_p1=%b rsta=%b exp at most one, none in reset",
                      cyc, gnt_p0, gnt_p1, rsta);

        if (rvalid_p0 === 1'b1) begin
            n_chk++;
            if (sb0.size() == 0) begin
                $display("FAIL rvalid_p0_unexpected cyc=%0d got rvalid_p0=1 exp 0", cyc);
            end else begin
                e = sb0.pop_front();
                if (rdata_p0 === e.data && cyc == e.cyc) n_pass++;
                else $display("FAIL rdata_p0 got %h at cyc %0d exp %h at cyc %0d", rdata_p0, cyc, e.data, e.cyc);
                last0 = e.data;
            end
        end else begin
            n_chk++;
            if (rvalid_p0 === 1'b0 && rdata_p0 === last0) n_pass++;
            else $display("FAIL rdata_p0_hold cyc=%0d got %h rvalid=%b exp %h", cyc, rdata_p0, rvalid_p0, last0);
        end

        if (rvalid_p1 === 1'b1) begin
            n_chk++;
            if (sb1.size() == 0) begin
                $display("FAIL rvalid_p1_unexpected cyc=%0d got rvalid_p1=1 exp 0", cyc);
            end else begin
                e = sb1.pop_front();
                if (rdata_p1 === e.data && cyc == e.cyc) n_pass++;
                else $display("FAIL rdata_p1 got %h at cyc %0d exp %h at cyc %0d", rdata_p1, cyc, e.data, e.cyc);
                last1 = e.data;
            end
        end else begin
            n_chk++;
            if (rvalid_p1 === 1'b0 && rdata_p1 === last1) n_pass++;
            else $display("FAIL rdata_p1_hold cyc=%0d got %h rvalid=%b exp %h", cyc, rdata_p1, rvalid_p1, last1);
        end

        if (rsta) begin
            exp_ena = 0; exp_wea = 0; exp_addra = 0; exp_dina = 0;
            last0 = 0; last1 = 0;
            sb0.delete(); sb1.delete();
        end else if ((req_p0 && gnt_p0) || (req_p1 && gnt_p1)) begin
            if (gnt_p1) begin
                m_we = we_p1; m_be = be_p1; m_addr = addr_p1; m_wdata = wdata_p1;
            end else begin
                m_we = we_p0; m_be = be_p0; m_addr = addr_p0; m_wdata = wdata_p0;
            end
            exp_wea = 0;
            exp_ena = 0;
            if (!m_we) begin
                exp_ena = 1; exp_addra = m_addr;
                e.data = shadow[m_addr[9:2]];
                e.cyc  = cyc + 2;
                if (gnt_p1) sb1.push_back(e); else sb0.push_back(e);
            end else if (m_be != 4'b0000) begin
                exp_ena = 1; exp_wea = m_be; exp_addra = m_addr; exp_dina = m_wdata;
                for (int b = 0; b < 4; b++) begin
                    if (m_be[b]) shadow[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
                end
            end
        end else begin
            exp_ena = 0; exp_wea = 0;
        end
    end

    task automatic present();
        if (q0.size() > 0) begin
            req_p0 = 1; we_p0 = q0[0].we; lock_p0 = q0[0].lock; be_p0 = q0[0].be;
            addr_p0 = q0[0].addr; wdata_p0 = q0[0].wdata;
        end else begin
            req_p0 = 0; lock_p0 = 0;
        end
        if (q1.size() > 0) begin
            req_p1 = 1; we_p1 = q1[0].we; lock_p1 = q1[0].lock; be_p1 = q1[0].be;
            addr_p1 = q1[0].addr; wdata_p1 = q1[0].wdata;
        end else begin
            req_p1 = 0; lock_p1 = 0;
        end
    endtask

    task automatic run(input int budget);
        int   n = 0;
        logic g0, g1;
        txn_t t;
        gseq.delete();
        present();
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
            @(negedge clka);
            g0 = req_p0 && gnt_p0;
            g1 = req_p1 && gnt_p1;
            if (g0) gseq.push_back(0);
            if (g1) gseq.push_back(1);
            @(posedge clka); #1;
            if (g0) t = q0.pop_front();
            if (g1) t = q1.pop_front();
            present();
            n++;
        end
        n_chk++;
        if (q0.size() == 0 && q1.size() == 0) n_pass++;
        else $display("FAIL run_budget got %0d/%0d txns left exp 0/0", q0.size(), q1.size());
        q0.delete(); q1.delete();
        present();
        repeat (4) @(posedge clka);
        #1;
        n_chk++;
        if (sb0.size() == 0 && sb1.size() == 0) n_pass++;
        else $display("FAIL read_drain got %0d/%0d reads outstanding exp 0/0", sb0.size(), sb1.size());
    endtask

    task automatic do_reset();
        rsta = 1;
        repeat (2) @(posedge clka);
        #1 rsta = 0;
    endtask

    task automatic test_reset();
        req_p0 = 1; req_p1 = 1; we_p0 = 0; we_p1 = 0;
        repeat (2) begin
            @(negedge clka);
            n_chk++;
            if (gnt_p0 === 0 && gnt_p1 === 0 && ena === 0 && wea === 0 && addra === 0 && dina === 0 &&
                rvalid_p0 === 0 && rvalid_p1 === 0 && rdata_p0 === 0 && rdata_p1 === 0) n_pass++;
            else $display("FAIL reset_state got gnt=%b%b ena=%b wea=%b addra=%h dina=%h rv=%b%b exp all 0",
                          gnt_p0, gnt_p1, ena, wea, addra, dina, rvalid_p0, rvalid_p1);
        end
        @(posedge clka); #1;
        rsta = 0; req_p1 = 0; addr_p0 = 32'h20;
        @(negedge clka);
        n_chk++;
        if (gnt_p0 === 1) n_pass++;
        else $display("FAIL reset_first_gnt_p0 got %b exp 1", gnt_p0);
        @(posedge clka); #1;
        req_p0 = 0; rsta = 1;
        @(posedge clka); #1;
        @(negedge clka);
        n_chk++;
        if (ena === 0 && rvalid_p0 === 0 && addra === 0) n_pass++;
        else $display("FAIL reset_midread got ena=%b rvalid_p0=%b addra=%h exp 0 0 0", ena, rvalid_p0, addra);
        @(posedge clka); #1;
        rsta = 0;
        repeat (3) begin
            @(negedge clka);
            n_chk++;
            if (rvalid_p0 === 0 && rvalid_p1 === 0) n_pass++;
            else $display("FAIL reset_discard got rvalid=%b%b exp 00", rvalid_p0, rvalid_p1);
        end
        @(posedge clka); #1;
        req_p1 = 1; we_p1 = 0; lock_p1 = 0; addr_p1 = 32'h24;
        @(negedge clka);
        n_chk++;
        if (gnt_p1 === 1 && gnt_p0 === 0) n_pass++;
        else $display("FAIL reset_first_gnt_p1 got gnt_p1=%b gnt_p0=%b exp 1 0", gnt_p1, gnt_p0);
        @(posedge clka); #1;
        req_p1 = 0;
        repeat (4) @(posedge clka);
        #1;
    endtask

    task automatic test_write_read();
        q0.push_back(wr(32'h10, 32'h5555555D, 4'b1111));
        q0.push_back(rd(32'h10, 1'b0));
        run(20);
        n_chk++;
        if (rdata_p0 === 32'h5555555D) n_pass++;
        else $display("FAIL write_read got %h exp 5555555d", rdata_p0);
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rd(32'h100 + 4 * i, 1'b0));
            q1.push_back(rd(32'h200 + 4 * i, 1'b0));
        end
        run(30);
        n_chk++;
        if (gseq.size() == 8) n_pass++;
        else $display("FAIL contention_count got %0d exp 8", gseq.size());
        for (int i = 0; i < gseq.size(); i++) begin
            n_chk++;
            if (gseq[i] == (i % 2)) n_pass++;
            else $display("FAIL contention_order idx %0d got p%0d exp p%0d", i, gseq[i], i % 2);
        end
    endtask

    task automatic test_lock();
        int exp_seq[7] = '{0, 1, 1, 1, 1, 0, 1};
        do_reset();
        q0.push_back(rd(32'h30, 1'b0));
        q0.push_back(rd(32'h34, 1'b0));
        for (int i = 0; i < 4; i++) q1.push_back(rd(32'h40 + 4 * i, 1'b1));
        q1.push_back(rd(32'h50, 1'b0));
        run(30);
        n_chk++;
        if (gseq.size() == 7) n_pass++;
        else $display("FAIL lock_count got %0d exp 7", gseq.size());
        for (int i = 0; i < gseq.size() && i < 7; i++) begin
            n_chk++;
            if (gseq[i] == exp_seq[i]) n_pass++;
            else $display("FAIL lock_order idx %0d got p%0d exp p%0d", i, gseq[i], exp_seq[i]);
        end
        req_p1 = 1; we_p1 = 0; lock_p1 = 1; addr_p1 = 32'h60;
        @(negedge clka);
        n_chk++;
        if (gnt_p1 === 1) n_pass++;
        else $display("FAIL lock_take got gnt_p1=%b exp 1", gnt_p1);
        @(posedge clka); #1;
        req_p1 = 0;
        req_p0 = 1; we_p0 = 0; lock_p0 = 0; addr_p0 = 32'h64;
        for (int i = 0; i < 3; i++) begin
            @(negedge clka);
            n_chk++;
            if (gnt_p0 === 0) n_pass++;
            else $display("FAIL lock_idle_hold cycle %0d got gnt_p0=%b exp 0", i, gnt_p0);
        end
        @(posedge clka); #1;
        lock_p1 = 0;
        @(negedge clka);
        n_chk++;
        if (gnt_p0 === 1) n_pass++;
        else $display("FAIL lock_release got gnt_p0=%b exp 1", gnt_p0);
        @(posedge clka); #1;
        req_p0 = 0;
        repeat (4) @(posedge clka);
        #1;
    endtask

    task automatic test_byte_enables();
        q0.push_back(wr(32'h80, 32'hFFFFFFFF, 4'b1111));
        q0.push_back(wr(32'h80, 32'h00000000, 4'b0101));
        q0.push_back(rd(32'h80, 1'b0));
        run(20);
        n_chk++;
        if (rdata_p0 === 32'hFF00FF00) n_pass++;
        else $display("FAIL byte_enable_merge got %h exp ff00ff00", rdata_p0);
        req_p0 = 1; we_p0 = 1; be_p0 = 4'b0000; addr_p0 = 32'h84; wdata_p0 = 32'h12345678;
        @(negedge clka);
        n_chk++;
        if (gnt_p0 === 1) n_pass++;
        else $display("FAIL be0_gnt got %b exp 1", gnt_p0);
        @(posedge clka); #1;
        req_p0 = 0; we_p0 = 0;
        @(negedge clka);
        n_chk++;
        if (ena === 0 && wea === 4'b0000) n_pass++;
        else $display("FAIL be0_noop got ena=%b wea=%b exp 0 0000", ena, wea);
        q0.push_back(rd(32'h84, 1'b0));
        run(10);
        n_chk++;
        if (rdata_p0 === 32'hA5A50021) n_pass++;
        else $display("FAIL be0_unchanged got %h exp a5a50021", rdata_p0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        q0.push_back(wr(32'hC0, 32'hCAFEF00D, 4'b1111));
        q1.push_back(rd(32'hC0, 1'b0));
        q1.push_back(rd(32'hC4, 1'b0));
        q0.push_back(rd(32'hC0, 1'b0));
        run(20);
        n_chk++;
        if (rdata_p1 === 32'hA5A50031 && rdata_p0 === 32'hCAFEF00D) n_pass++;
        else $display("FAIL back_to_back got p0=%h p1=%h exp cafef00d a5a50031", rdata_p0, rdata_p1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_lock();
        test_byte_enables();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
